// File: rtl/spi_master_param_if.sv
// CPU-side load/in/out bus plus SPI pins for spi_master_param.
// The master modport is the controller's view; slave is the CPU/peripheral side.
interface spi_master_param_if;
  logic        CDONE;
  logic        load;
  logic [15:0] in;
  logic        SDI;
  logic        SCK;
  logic        CSX;
  logic        SDO;
  logic [15:0] out;

  modport master (
    input  CDONE, load, in, SDI,
    output SCK, CSX, SDO, out
  );

  modport slave (
    output CDONE, load, in, SDI,
    input  SCK, CSX, SDO, out
  );
endinterface

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with WIDTH-bit transfers, DIV-cycle SCK half-periods and fixed CPOL/CPHA.
// Memory-mapped view: load/in starts a transfer or deasserts CSX; out[15] is busy.
module spi_master_param #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  spi_master_param_if.master bus
);
  typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tx_reg, tx_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [WIDTH-1:0] rx_data_reg, rx_data_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       div_cnt_reg, div_cnt_next;
  logic             sck_reg, sck_next;
  logic             csx_reg, csx_next;
  logic             sdo_reg, sdo_next;

  logic             busy;
  logic             edge_hit;
  logic [WIDTH:0]   rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [15:0]      out_word;
  logic             unused_bits;

  assign busy        = (state_reg != IDLE);
  assign edge_hit    = (div_cnt_reg == 8'(DIV - 1));
  assign rx_shift    = {rx_reg, bus.SDI};
  assign tx_shift    = tx_reg << 1;
  assign unused_bits = ^{bus.in, rx_shift[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_data_reg <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      sck_reg     <= CPOL;
      csx_reg     <= 1'b1;
      sdo_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_data_reg <= rx_data_next;
      bit_cnt_reg <= bit_cnt_next;
      div_cnt_reg <= div_cnt_next;
      sck_reg     <= sck_next;
      csx_reg     <= csx_next;
      sdo_reg     <= sdo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_data_next = rx_data_reg;
    bit_cnt_next = bit_cnt_reg;
    div_cnt_next = div_cnt_reg;
    sck_next     = sck_reg;
    csx_next     = csx_reg;
    sdo_next     = sdo_reg;

    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          if (bus.in[14]) begin
            csx_next = 1'b1;
          end else begin
            csx_next     = 1'b0;
            tx_next      = bus.in[WIDTH-1:0];
            bit_cnt_next = '0;
            div_cnt_next = '0;
            state_next   = LEAD;
            if (!CPHA) sdo_next = bus.in[WIDTH-1];
          end
        end
      end
      LEAD: begin
        div_cnt_next = edge_hit ? 8'd0 : div_cnt_reg + 8'd1;
        if (edge_hit) begin
          sck_next   = ~sck_reg;
          state_next = TRAIL;
          if (!CPHA) begin
            rx_next = rx_shift[WIDTH-1:0];
          end else begin
            sdo_next = tx_reg[WIDTH-1];
            tx_next  = tx_shift;
          end
        end
      end
      TRAIL: begin
        div_cnt_next = edge_hit ? 8'd0 : div_cnt_reg + 8'd1;
        if (edge_hit) begin
          sck_next     = ~sck_reg;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          state_next   = LEAD;
          if (!CPHA) begin
            tx_next  = tx_shift;
            sdo_next = tx_shift[WIDTH-1];
          end else begin
            rx_next = rx_shift[WIDTH-1:0];
          end
          // Last trailing edge: publish the word and park SCK/SDO at idle levels.
          if (bit_cnt_reg == 4'(WIDTH - 1)) begin
            state_next   = IDLE;
            sck_next     = CPOL;
            sdo_next     = 1'b0;
            bit_cnt_next = '0;
            rx_data_next = CPHA ? rx_shift[WIDTH-1:0] : rx_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_word              = '0;
    out_word[WIDTH-1:0]   = rx_data_reg;
    out_word[15]          = busy;
  end

  assign bus.out = out_word;
  assign bus.SCK = sck_reg;
  assign bus.CSX = csx_reg | ~bus.CDONE;
  assign bus.SDO = sdo_reg;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: dut_a runs the default mode-0 configuration, dut_b runs WIDTH=12, DIV=3, mode 3.
// A behavioural slave in each transfer loop returns a fixed word and records MOSI bits.
module tb_spi_master_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  int   checks   = 0;
  int   failures = 0;

  spi_master_param_if bus_a();
  spi_master_param_if bus_b();

  spi_master_param #(.WIDTH(8), .DIV(1), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a)
  );

  spi_master_param #(.WIDTH(12), .DIV(3), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input int sel, input logic ld, input logic [15:0] din);
    if (sel == 0) begin bus_a.load = ld; bus_a.in = din; end
    else          begin bus_b.load = ld; bus_b.in = din; end
  endtask

  task automatic set_sdi(input int sel, input logic b);
    if (sel == 0) bus_a.SDI = b;
    else          bus_b.SDI = b;
  endtask

  task automatic sample(input int sel, output logic sck, output logic sdo,
                        output logic csx, output logic [15:0] o);
    if (sel == 0) begin sck = bus_a.SCK; sdo = bus_a.SDO; csx = bus_a.CSX; o = bus_a.out; end
    else          begin sck = bus_b.SCK; sdo = bus_b.SDO; csx = bus_b.CSX; o = bus_b.out; end
  endtask

  // Issues one command and follows it to completion; ign_cycle>0 pulses load=0x0055 on that busy cycle.
  task automatic xfer(input int sel, input int width, input bit cpol, input bit cpha,
                      input logic [15:0] cmd, input logic [15:0] slave_word, input int ign_cycle,
                      output logic [15:0] mosi, output int pulses, output int busy_cyc,
                      output int min_half, output int max_half, output int csx_hi,
                      output logic csx_end, output logic [15:0] out_after);
    logic sck, sdo, csx, prev;
    logic [15:0] o;
    int idx, run;
    bit done;
    mosi = '0; pulses = 0; busy_cyc = 0; min_half = 1000; max_half = 0;
    csx_hi = 0; csx_end = 1'b1; out_after = '0;
    idx = 0; run = 0; prev = cpol; done = 1'b0;
    @(negedge clk);
    set_sdi(sel, cpha ? 1'b0 : slave_word[width-1]);
    drive(sel, 1'b1, cmd);
    @(negedge clk);
    drive(sel, 1'b0, 16'h0000);
    for (int c = 0; c < 2000 && !done; c++) begin
      sample(sel, sck, sdo, csx, o);
      if (o[15]) begin
        busy_cyc++;
        if (csx) csx_hi++;
      end
      if (sck != prev) begin
        if (run > 0) begin
          if (run < min_half) min_half = run;
          if (run > max_half) max_half = run;
        end
        run = 0;
        if (sck != cpol) begin
          pulses++;
          mosi = {mosi[14:0], sdo};
          if (cpha) begin
            if (idx < width) set_sdi(sel, slave_word[width-1-idx]);
            idx++;
          end
        end else if (!cpha) begin
          idx++;
          if (idx < width) set_sdi(sel, slave_word[width-1-idx]);
        end
      end
      if (o[15]) run++;
      prev = sck;
      if (!o[15] && busy_cyc > 0) begin
        done      = 1'b1;
        out_after = o;
        csx_end   = csx;
      end else begin
        drive(sel, (ign_cycle > 0) && (busy_cyc == ign_cycle), 16'h0055);
        @(negedge clk);
      end
    end
    drive(sel, 1'b0, 16'h0000);
    check("xfer_completed", 32'(done), 32'd1);
  endtask

  logic [15:0] mosi, o, out_prev;
  int   pulses, busy_cyc, min_h, max_h, csx_hi, extra_busy;
  logic csx_end, sck, sdo, csx;

  initial begin
    bus_a.CDONE = 1'b1; bus_a.load = 1'b0; bus_a.in = '0; bus_a.SDI = 1'b0;
    bus_b.CDONE = 1'b1; bus_b.load = 1'b0; bus_b.in = '0; bus_b.SDI = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);

    sample(0, sck, sdo, csx, o);
    check("rst_a_out", o, 16'h0000);
    check("rst_a_csx", csx, 1'b1);
    check("rst_a_sck", sck, 1'b0);
    check("rst_a_sdo", sdo, 1'b0);
    sample(1, sck, sdo, csx, o);
    check("rst_b_sck_idle_high", sck, 1'b1);
    check("rst_b_csx", csx, 1'b1);

    // Mode 0 default transfer
    xfer(0, 8, 1'b0, 1'b0, 16'h00A5, 16'h003C, 0, mosi, pulses, busy_cyc, min_h, max_h, csx_hi, csx_end, o);
    check("t1_mosi", mosi, 16'h00A5);
    check("t1_pulses", pulses, 8);
    check("t1_busy_cycles", busy_cyc, 16);
    check("t1_out", o, 16'h003C);
    check("t1_csx_low_during", csx_hi, 0);
    check("t1_csx_low_after", csx_end, 1'b0);

    // load while busy is ignored
    xfer(0, 8, 1'b0, 1'b0, 16'h00C3, 16'h0081, 3, mosi, pulses, busy_cyc, min_h, max_h, csx_hi, csx_end, o);
    check("t2_mosi", mosi, 16'h00C3);
    check("t2_busy_cycles", busy_cyc, 16);
    check("t2_out", o, 16'h0081);
    extra_busy = 0;
    repeat (20) begin
      @(negedge clk);
      sample(0, sck, sdo, csx, o);
      if (o[15]) extra_busy++;
    end
    check("t2_no_second_xfer", extra_busy, 0);

    // CS deassert command
    sample(0, sck, sdo, csx, out_prev);
    drive(0, 1'b1, 16'h4000);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000);
    sample(0, sck, sdo, csx, o);
    check("t3_csx_high", csx, 1'b1);
    check("t3_busy_low", o[15], 1'b0);
    check("t3_out_unchanged", o, 16'h0081);

    // WIDTH=12, DIV=3, mode 3; bits 13:12 of in must be ignored
    xfer(1, 12, 1'b1, 1'b1, 16'h3ABC, 16'h05A5, 0, mosi, pulses, busy_cyc, min_h, max_h, csx_hi, csx_end, o);
    check("t4_mosi", mosi, 16'h0ABC);
    check("t4_pulses", pulses, 12);
    check("t4_busy_cycles", busy_cyc, 72);
    check("t4_min_half", min_h, 3);
    check("t4_max_half", max_h, 3);
    check("t4_out", o, 16'h05A5);
    sample(1, sck, sdo, csx, o);
    check("t4_sck_idle_high", sck, 1'b1);

    // Asynchronous reset mid-transfer
    @(negedge clk);
    set_sdi(0, 1'b1);
    drive(0, 1'b1, 16'h00F0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    sample(0, sck, sdo, csx, o);
    check("t5_busy_before_rst", o[15], 1'b1);
    rst_a_n = 1'b0;
    #1;
    sample(0, sck, sdo, csx, o);
    check("t5_rst_out", o, 16'h0000);
    check("t5_rst_csx", csx, 1'b1);
    check("t5_rst_sck", sck, 1'b0);
    check("t5_rst_sdo", sdo, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    xfer(0, 8, 1'b0, 1'b0, 16'h005A, 16'h00A5, 0, mosi, pulses, busy_cyc, min_h, max_h, csx_hi, csx_end, o);
    check("t5_post_mosi", mosi, 16'h005A);
    check("t5_post_out", o, 16'h00A5);
    check("t5_post_busy_cycles", busy_cyc, 16);

    // CDONE low gates CSX only
    bus_a.CDONE = 1'b0;
    xfer(0, 8, 1'b0, 1'b0, 16'h0011, 16'h0000, 0, mosi, pulses, busy_cyc, min_h, max_h, csx_hi, csx_end, o);
    check("t6_csx_high_during", csx_hi, 16);
    check("t6_busy_cycles", busy_cyc, 16);
    check("t6_mosi", mosi, 16'h0011);
    check("t6_csx_high_after", csx_end, 1'b1);
    bus_a.CDONE = 1'b1;
    #1;
    check("t6_csx_low_cdone", bus_a.CSX, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
